rr_bus_mux: RTL and testbench

//  K-source, N-bit arbitrated bus multiplexer with a registered output stage.

---
 rtl/rr_bus_mux.sv | 98 +++++++++
 tb/tb_rr_bus_mux.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rr_bus_mux.sv
// K-source arbitrated bus multiplexer with a one-entry registered output stage.
// The arbiter is round-robin or fixed-priority, and the output uses a valid/ready handshake.
//
// state | meaning
// EMPTY | output register holds no beat, out_valid=0
// FULL  | output register holds a beat, out_valid=1
module rr_bus_mux #(
  parameter int N  = 16,
  parameter int K  = 4,
  parameter int RR = 1,
  parameter int SW = 2
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic [K-1:0]   req,
  input  logic [K*N-1:0] data_in,
  output logic [K-1:0]   grant,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_data,
  output logic [SW-1:0]  out_src
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] ptr, ptr_nxt, winner, idx;
  logic          found, any_req, load;
  logic [N-1:0]  win_data;

  // The search starts at ptr and wraps modulo K. Fixed priority always starts at 0.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int o = 0; o < K; o++) begin
      if (RR != 0) idx = SW'((int'(ptr) + o) % K);
      else         idx = SW'(o);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < K; i++)
      if (winner == SW'(i)) win_data = data_in[i*N +: N];
  end

  assign any_req = |req;
  assign load    = any_req & (~out_valid | out_ready);
  assign ptr_nxt = SW'((int'(winner) + 1) % K);

  always_comb begin
    grant = '0;
    if (load && resetn) grant = K'(1) << winner;
  end

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= EMPTY;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (load) state_nxt = FULL;
      FULL:    if (out_ready && !any_req) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid = (state == FULL);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_data <= '0;
      out_src  <= '0;
    end else if (load) begin
      out_data <= win_data;
      out_src  <= winner;
    end
  end

  // The pointer only advances for round-robin. It stays at zero under fixed priority.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)               ptr <= '0;
    else if (RR != 0 && load)  ptr <= ptr_nxt;
  end

endmodule

// File: tb/tb_rr_bus_mux.sv
// Directed bench for rr_bus_mux. Expected beats are queued by the stimulus thread.
// A monitor pops each queued beat and compares it when the DUT hands it off.
module tb_rr_bus_mux;
  localparam int N = 16, K = 4, SW = 2;

  logic           clock = 1'b0;
  logic           resetn;
  logic [K-1:0]   req, req_f;
  logic [K*N-1:0] data_in;
  logic [K-1:0]   grant, grant_f;
  logic           out_valid, out_valid_f;
  logic           out_ready;
  logic           out_ready_f;
  logic [N-1:0]   out_data, out_data_f;
  logic [SW-1:0]  out_src, out_src_f;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [15:0] dv [4];

  always #5 clock = ~clock;

  rr_bus_mux #(.N(N), .K(K), .RR(1), .SW(SW)) u_rr (
    .clock(clock), .resetn(resetn), .req(req), .data_in(data_in), .grant(grant),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src)
  );

  rr_bus_mux #(.N(N), .K(K), .RR(0), .SW(SW)) u_fp (
    .clock(clock), .resetn(resetn), .req(req_f), .data_in(data_in), .grant(grant_f),
    .out_valid(out_valid_f), .out_ready(out_ready_f), .out_data(out_data_f), .out_src(out_src_f)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input int src);
    exp_q.push_back({16'(src), dv[src]});
  endtask

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  initial begin
    dv[0] = 16'h1111; dv[1] = 16'h2222; dv[2] = 16'h3333; dv[3] = 16'h4444;
    data_in     = {dv[3], dv[2], dv[1], dv[0]};
    resetn      = 1'b0;
    req         = 4'b1111;
    req_f       = 4'b0000;
    out_ready   = 1'b1;
    out_ready_f = 1'b1;

    fork
      forever begin
        @(negedge clock);
        if (resetn && out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_beat", {16'(out_src), out_data}, 32'hFFFF_FFFF);
          end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk("sb_out_src", 32'(out_src), 32'(e[31:16]));
            chk("sb_out_data", 32'(out_data), 32'(e[15:0]));
          end
        end
      end
    join_none

    // Reset with every source requesting
    #3;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    req = 4'b0000;
    @(negedge clock);
    resetn = 1'b1;

    // Round-robin fairness
    for (int c = 0; c < 8; c++) begin
      cyc();
      req = 4'b1111;
      #1;
      chk($sformatf("rr_grant_%0d", c), 32'(grant), 32'(4'b0001 << (c % 4)));
      push_beat(c % 4);
    end

    // Backpressure while FULL holding the source-3 beat
    cyc();
    out_ready = 1'b0;
    req = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_grant_%0d", c), 32'(grant), 0);
      chk($sformatf("bp_data_%0d", c), 32'(out_data), 32'(dv[3]));
      chk($sformatf("bp_valid_%0d", c), 32'(out_valid), 1);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_grant", 32'(grant), 32'(4'b0100));
    push_beat(2);
    cyc();
    req = 4'b0000;
    cyc();
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_hold_data", 32'(out_data), 32'(dv[2]));
    chk("drain_hold_src", 32'(out_src), 2);

    // The pointer is now 3. The search wraps to 0, then continues from 1.
    req = 4'b0011;
    #1;
    chk("wrap_grant", 32'(grant), 32'(4'b0001));
    push_beat(0);
    cyc();
    #1;
    chk("wrap_next_ptr_grant", 32'(grant), 32'(4'b0010));
    push_beat(1);
    cyc();
    req = 4'b0000;
    cyc();

    // Async reset while FULL and stalled
    req = 4'b1000;
    #1;
    chk("pre_rst_grant", 32'(grant), 32'(4'b1000));
    cyc();
    req = 4'b0000;
    out_ready = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(out_valid), 1);
    #1;
    resetn = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_data", 32'(out_data), 0);
    @(negedge clock);
    resetn = 1'b1;
    out_ready = 1'b1;
    cyc();
    req = 4'b1111;
    #1;
    chk("post_rst_ptr_grant", 32'(grant), 32'(4'b0001));
    push_beat(0);
    cyc();
    req = 4'b0000;

    // Fixed priority: source 3 starves until req[1] drops
    req_f = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("fp_grant_%0d", c), 32'(grant_f), 32'(4'b0010));
      cyc();
      chk($sformatf("fp_src_%0d", c), 32'(out_src_f), 1);
    end
    req_f = 4'b1000;
    #1;
    chk("fp_starve_end_grant", 32'(grant_f), 32'(4'b1000));
    cyc();
    chk("fp_starve_end_src", 32'(out_src_f), 3);
    chk("fp_starve_end_data", 32'(out_data_f), 32'(dv[3]));
    req_f = 4'b0000;

    repeat (4) cyc();
    chk("sb_queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
